// File: rtl/aes_pkg.sv
// Shared AES constants, FSM state type and GF(2^8) helpers.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package aes_pkg;

    localparam logic [3:0] NR_128 = 4'd10;
    localparam logic [3:0] NR_192 = 4'd12;
    localparam logic [3:0] NR_256 = 4'd14;

    localparam logic [1:0] MODE_128 = 2'd0;
    localparam logic [1:0] MODE_192 = 2'd1;
    localparam logic [1:0] MODE_256 = 2'd2;
    localparam logic [1:0] MODE_BAD = 2'd3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ROUND = 2'd1,
        FINAL = 2'd2,
        DONE  = 2'd3
    } aes_state_e;

    // Unknown encodings fall back to AES-128 round count.
    function automatic logic [3:0] nr_of_mode(input logic [1:0] mode);
        case (mode)
            MODE_192: nr_of_mode = NR_192;
            MODE_256: nr_of_mode = NR_256;
            default:  nr_of_mode = NR_128;
        endcase
    endfunction

    // Multiply by x modulo x^8+x^4+x^3+x+1 (0x11B).
    function automatic logic [7:0] xtime(input logic [7:0] b);
        xtime = {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] pmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] m;
        p = 8'h00;
        m = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ m;
            m = xtime(m);
        end
        pmul = p;
    endfunction

    function automatic logic [31:0] inv_mix_col(input logic [31:0] col);
        logic [7:0] a0, a1, a2, a3;
        a0 = col[31:24];
        a1 = col[23:16];
        a2 = col[15:8];
        a3 = col[7:0];
        inv_mix_col = {
            pmul(a0, 8'h0e) ^ pmul(a1, 8'h0b) ^ pmul(a2, 8'h0d) ^ pmul(a3, 8'h09),
            pmul(a0, 8'h09) ^ pmul(a1, 8'h0e) ^ pmul(a2, 8'h0b) ^ pmul(a3, 8'h0d),
            pmul(a0, 8'h0d) ^ pmul(a1, 8'h09) ^ pmul(a2, 8'h0e) ^ pmul(a3, 8'h0b),
            pmul(a0, 8'h0b) ^ pmul(a1, 8'h0d) ^ pmul(a2, 8'h09) ^ pmul(a3, 8'h0e)
        };
    endfunction

endpackage

// File: rtl/aes_inv_round.sv
// One AES inverse round: InvShiftRows, InvSubBytes, AddRoundKey, InvMixColumns unless last.
// Latency: combinational.
// Backpressure: n/a.
module aes_inv_round
    import aes_pkg::*;
(
    input  logic [127:0] state,
    input  logic [127:0] rk,
    input  logic         last,
    output logic [127:0] next_state
);

    logic [7:0]   sr_byte [16];
    logic [7:0]   sb_byte [16];
    logic [127:0] sub_v;
    logic [127:0] added;
    logic [127:0] mixed;

    // Byte i sits at row i%4, column i/4; row r is rotated right by r.
    for (genvar i = 0; i < 16; i++) begin : g_byte
        localparam int R   = i % 4;
        localparam int C   = i / 4;
        localparam int SRC = R + 4 * ((C - R + 4) % 4);
        assign sr_byte[i] = state[127-8*SRC -: 8];
        aes_inv_sbox u_sbox (
            .x (sr_byte[i]),
            .y (sb_byte[i])
        );
        assign sub_v[127-8*i -: 8] = sb_byte[i];
    end

    assign added = sub_v ^ rk;

    for (genvar c = 0; c < 4; c++) begin : g_col
        assign mixed[127-32*c -: 32] = inv_mix_col(added[127-32*c -: 32]);
    end

    assign next_state = last ? added : mixed;

endmodule

// File: rtl/aes_inv_sbox.sv
// AES inverse S-box, one byte.
// Latency: combinational.
// Backpressure: n/a.
module aes_inv_sbox (
    input  logic [7:0] x,
    output logic [7:0] y
);

    localparam logic [7:0] INV_SBOX [256] = '{
        8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
        8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
        8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
        8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
        8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
        8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
        8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
        8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
        8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
        8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
        8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
        8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
        8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
        8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
        8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
        8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
    };

    assign y = INV_SBOX[x];

endmodule

// File: rtl/aes_inv_cipher_var.sv
// Iterative AES-128/192/256 inverse cipher with a writable round-key store.
// Latency: out_valid rises NR+1 cycles after accept; one block in flight.
// Backpressure: result held in DONE until out_ready; in_ready only in IDLE.
module aes_inv_cipher_var
    import aes_pkg::*;
#(
    parameter int NR_MAX = 14,
    parameter int RK_AW  = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       nr_mode,
    input  logic             rk_we,
    input  logic [RK_AW-1:0] rk_addr,
    input  logic [127:0]     rk_wdata,
    output logic             rk_err,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [127:0]     in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [127:0]     out_data,
    output logic             mode_err
);

    localparam logic [RK_AW-1:0] ADDR_MAX = RK_AW'(NR_MAX);

    aes_state_e       state_q, state_d;
    logic [RK_AW-1:0] rcnt_q;
    logic [RK_AW-1:0] nr_idx;
    logic [127:0]     blk_q;
    logic [127:0]     rk_mem [NR_MAX+1];
    logic [127:0]     rk_rd;
    logic [127:0]     round_out;
    logic             accept;
    logic             wr_ok;
    logic             last;

    assign in_ready = (state_q == IDLE);
    assign accept   = in_valid & in_ready;
    assign nr_idx   = RK_AW'(nr_of_mode(nr_mode));
    assign wr_ok    = rk_we & (state_q == IDLE) & (rk_addr <= ADDR_MAX);
    assign last     = (state_q == FINAL);
    // rcnt reaches 0 on entry to FINAL, so one read port serves every round.
    assign rk_rd    = rk_mem[rcnt_q];

    // Key store is deliberately left out of reset; reads see pre-write data.
    always_ff @(posedge clk) begin
        if (wr_ok) rk_mem[rk_addr] <= rk_wdata;
    end

    aes_inv_round u_round (
        .state      (blk_q),
        .rk         (rk_rd),
        .last       (last),
        .next_state (round_out)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (in_valid) state_d = ROUND;
            ROUND:   if (rcnt_q == RK_AW'(1)) state_d = FINAL;
            FINAL:   state_d = DONE;
            DONE:    if (out_valid && out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            rcnt_q    <= '0;
            blk_q     <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            rk_err    <= 1'b0;
            mode_err  <= 1'b0;
        end else begin
            state_q  <= state_d;
            rk_err   <= rk_we & ~wr_ok;
            mode_err <= accept & (nr_mode == MODE_BAD);
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        blk_q  <= in_data ^ rk_mem[nr_idx];
                        rcnt_q <= nr_idx - RK_AW'(1);
                    end
                end
                ROUND: begin
                    blk_q  <= round_out;
                    rcnt_q <= rcnt_q - RK_AW'(1);
                end
                FINAL: out_data <= round_out;
                // First DONE cycle registers the valid; later cycles wait for the sink.
                DONE: begin
                    if (!out_valid)     out_valid <= 1'b1;
                    else if (out_ready) out_valid <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_aes_inv_cipher_var.sv
// Self-checking bench: known-answer vectors plus random blocks against a byte-level InvCipher model.
module tb_aes_inv_cipher_var;

    localparam int NR_MAX = 14;
    localparam int RK_AW  = 4;
    localparam logic [127:0] PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] C128 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] C192 = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
    localparam logic [127:0] C256 = 128'h8ea2b7ca516745bfeafc49904b496089;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic [1:0]       nr_mode = 2'd0;
    logic             rk_we = 1'b0;
    logic [RK_AW-1:0] rk_addr = '0;
    logic [127:0]     rk_wdata = '0;
    logic             rk_err;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [127:0]     in_data = '0;
    logic             out_valid;
    logic             out_ready = 1'b1;
    logic [127:0]     out_data;
    logic             mode_err;

    always #5 clk = ~clk;

    aes_inv_cipher_var #(.NR_MAX(NR_MAX), .RK_AW(RK_AW)) dut (
        .clk       (clk),
        .rst       (rst),
        .nr_mode   (nr_mode),
        .rk_we     (rk_we),
        .rk_addr   (rk_addr),
        .rk_wdata  (rk_wdata),
        .rk_err    (rk_err),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .mode_err  (mode_err)
    );

    int n_chk = 0;
    int n_bad = 0;
    logic [7:0]   ginv_t [256];
    logic [7:0]   sb [256];
    logic [7:0]   isb [256];
    logic [127:0] mdl_rk [NR_MAX+1];
    logic [31:0]  w [60];

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Carry-less product reduced by 0x11B.
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [15:0] p;
        p = '0;
        for (int i = 0; i < 8; i++) if (b[i]) p = p ^ (16'(a) << i);
        for (int i = 15; i >= 8; i--) if (p[i]) p = p ^ (16'h11b << (i - 8));
        return p[7:0];
    endfunction

    function automatic logic [7:0] rotl(input logic [7:0] v, input int n);
        return (v << n) | (v >> (8 - n));
    endfunction

    function automatic logic [31:0] subword(input logic [31:0] t);
        return {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]};
    endfunction

    // FIPS-197 key expansion of key bytes 00,01,02,... into mdl_rk.
    task automatic expand_key(input int nk, input int nr);
        logic [255:0] key;
        logic [31:0]  t;
        logic [7:0]   rc;
        for (int i = 0; i < 32; i++) key[255-8*i -: 8] = 8'(i);
        for (int i = 0; i < nk; i++) w[i] = key[255-32*i -: 32];
        rc = 8'h01;
        for (int i = nk; i < 4 * (nr + 1); i++) begin
            t = w[i-1];
            if (i % nk == 0) begin
                t = subword({t[23:0], t[31:24]}) ^ {rc, 24'h0};
                rc = gmul(rc, 8'h02);
            end else if (nk > 6 && i % nk == 4) begin
                t = subword(t);
            end
            w[i] = w[i-nk] ^ t;
        end
        for (int r = 0; r <= nr; r++) mdl_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    function automatic logic [127:0] ref_decrypt(input logic [127:0] ct, input int nr);
        logic [7:0]   s [16];
        logic [7:0]   t [16];
        logic [7:0]   coef [4];
        logic [7:0]   acc;
        logic [127:0] v;
        coef[0] = 8'h0e; coef[1] = 8'h0b; coef[2] = 8'h0d; coef[3] = 8'h09;
        v = ct ^ mdl_rk[nr];
        for (int r = nr - 1; r >= 0; r--) begin
            for (int i = 0; i < 16; i++) s[i] = v[127-8*i -: 8];
            for (int row = 0; row < 4; row++)
                for (int col = 0; col < 4; col++)
                    t[row + 4*((col + row) % 4)] = isb[s[row + 4*col]];
            for (int i = 0; i < 16; i++) v[127-8*i -: 8] = t[i];
            v = v ^ mdl_rk[r];
            if (r > 0) begin
                for (int i = 0; i < 16; i++) s[i] = v[127-8*i -: 8];
                for (int c = 0; c < 4; c++)
                    for (int row = 0; row < 4; row++) begin
                        acc = 8'h00;
                        for (int k = 0; k < 4; k++) acc = acc ^ gmul(coef[(k - row + 4) % 4], s[4*c + k]);
                        t[4*c + row] = acc;
                    end
                for (int i = 0; i < 16; i++) v[127-8*i -: 8] = t[i];
            end
        end
        return v;
    endfunction

    task automatic load_keys(input int nr);
        for (int r = 0; r <= nr; r++) begin
            @(negedge clk);
            rk_we = 1'b1;
            rk_addr = RK_AW'(r);
            rk_wdata = mdl_rk[r];
        end
        @(negedge clk);
        rk_we = 1'b0;
    endtask

    // inject: 0 none, 1 key write while busy, 2 reset at round 5, 3 key write on accept.
    task automatic run_block(input string tag, input logic [127:0] ct, input logic [1:0] mode,
                             input int stall, input int inject, input logic [127:0] exp_pt);
        int nr;
        int cyc;
        bit aborted;
        logic [127:0] newk;
        nr = (mode == 2'd1) ? 12 : (mode == 2'd2) ? 14 : 10;
        aborted = 1'b0;
        newk = rnd128();
        @(negedge clk);
        chk({tag, "_in_ready"}, 128'(in_ready), 128'd1);
        in_valid = 1'b1;
        in_data = ct;
        nr_mode = mode;
        out_ready = (stall == 0);
        if (inject == 3) begin
            rk_we = 1'b1;
            rk_addr = RK_AW'(nr);
            rk_wdata = newk;
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_data = rnd128();
        nr_mode = 2'($urandom_range(0, 3));
        rk_we = 1'b0;
        if (inject == 3) mdl_rk[nr] = newk;
        chk({tag, "_mode_err"}, 128'(mode_err), 128'(mode == 2'd3));
        cyc = 0;
        while (out_valid !== 1'b1 && cyc < 40 && !aborted) begin
            if (inject == 1 && cyc == 3) begin
                rk_we = 1'b1;
                rk_addr = RK_AW'(3);
                rk_wdata = rnd128();
            end
            @(posedge clk);
            #1;
            cyc++;
            rk_we = 1'b0;
            if (cyc == 1) chk({tag, "_merr_clr"}, 128'(mode_err), 128'd0);
            if (inject == 3 && cyc == 1) chk({tag, "_wr_ok"}, 128'(rk_err), 128'd0);
            if (inject == 1 && cyc == 4) chk({tag, "_busy_rk_err"}, 128'(rk_err), 128'd1);
            if (inject == 1 && cyc == 5) chk({tag, "_busy_rk_clr"}, 128'(rk_err), 128'd0);
            if (inject == 2 && cyc == 5) begin
                rst = 1'b1;
                #1;
                chk({tag, "_rst_ov"}, 128'(out_valid), 128'd0);
                chk({tag, "_rst_rdy"}, 128'(in_ready), 128'd1);
                @(negedge clk);
                rst = 1'b0;
                @(posedge clk);
                #1;
                chk({tag, "_rel_rdy"}, 128'(in_ready), 128'd1);
                chk({tag, "_rel_ov"}, 128'(out_valid), 128'd0);
                aborted = 1'b1;
            end
        end
        if (!aborted) begin
            chk({tag, "_latency"}, 128'(cyc), 128'(nr + 1));
            chk({tag, "_data"}, out_data, exp_pt);
            for (int k = 0; k < stall; k++) begin
                @(posedge clk);
                #1;
                chk({tag, "_hold_vld"}, 128'(out_valid), 128'd1);
                chk({tag, "_hold_dat"}, out_data, exp_pt);
                chk({tag, "_hold_rdy"}, 128'(in_ready), 128'd0);
            end
            @(negedge clk);
            out_ready = 1'b1;
            @(posedge clk);
            #1;
            chk({tag, "_post_rdy"}, 128'(in_ready), 128'd1);
            chk({tag, "_post_vld"}, 128'(out_valid), 128'd0);
        end
    endtask

    initial begin
        logic [127:0] ct;
        logic [1:0]   m;
        int           nr;

        for (int a = 0; a < 256; a++) ginv_t[a] = 8'h00;
        for (int a = 1; a < 256; a++)
            for (int b = 1; b < 256; b++)
                if (gmul(8'(a), 8'(b)) == 8'h01) ginv_t[a] = 8'(b);
        for (int x = 0; x < 256; x++) begin
            logic [7:0] s;
            s = ginv_t[x];
            sb[x] = s ^ rotl(s, 1) ^ rotl(s, 2) ^ rotl(s, 3) ^ rotl(s, 4) ^ 8'h63;
            isb[x] = ginv_t[rotl(8'(x), 1) ^ rotl(8'(x), 3) ^ rotl(8'(x), 6) ^ 8'h05];
        end

        #1 rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_out_valid", 128'(out_valid), 128'd0);
        chk("rst_out_data", out_data, 128'd0);
        chk("rst_rk_err", 128'(rk_err), 128'd0);
        chk("rst_mode_err", 128'(mode_err), 128'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("rst_in_ready", 128'(in_ready), 128'd1);

        expand_key(4, 10);
        load_keys(10);
        run_block("kat128", C128, 2'd0, 0, 0, PT);

        expand_key(6, 12);
        load_keys(12);
        run_block("kat192", C192, 2'd1, 0, 0, PT);

        expand_key(8, 14);
        load_keys(14);
        run_block("kat256_bp", C256, 2'd2, 20, 0, PT);
        run_block("busy_wr", C256, 2'd2, 0, 1, PT);

        @(negedge clk);
        rk_we = 1'b1;
        rk_addr = RK_AW'(15);
        rk_wdata = rnd128();
        @(posedge clk);
        #1;
        rk_we = 1'b0;
        chk("addr15_rk_err", 128'(rk_err), 128'd1);
        @(posedge clk);
        #1;
        chk("addr15_rk_clr", 128'(rk_err), 128'd0);

        ct = rnd128();
        run_block("mode3", ct, 2'd3, 1, 0, ref_decrypt(ct, 10));

        run_block("rst_mid", C256, 2'd2, 0, 2, PT);
        run_block("after_rst", C256, 2'd2, 0, 0, PT);

        ct = rnd128();
        run_block("same_cyc_wr", ct, 2'd0, 0, 3, ref_decrypt(ct, 10));
        ct = rnd128();
        run_block("new_key", ct, 2'd0, 0, 0, ref_decrypt(ct, 10));

        for (int r = 0; r <= NR_MAX; r++) mdl_rk[r] = rnd128();
        load_keys(NR_MAX);
        for (int i = 0; i < 16; i++) begin
            ct = rnd128();
            m = 2'($urandom_range(0, 3));
            nr = (m == 2'd1) ? 12 : (m == 2'd2) ? 14 : 10;
            run_block($sformatf("rnd%0d", i), ct, m, $urandom_range(0, 3), 0, ref_decrypt(ct, nr));
        end

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule

// File: doc/aes_inv_cipher_var.md
AES_INV_CIPHER_VAR -- requirements
Module: aes_inv_cipher_var

Interface
REQ-001 SHALL have parameter NR_MAX, default 14, giving the maximum round count; the key store holds NR_MAX+1 round keys.
REQ-002 SHALL have parameter RK_AW, default 4, giving the round-key address width; RK_AW SHALL satisfy 2^RK_AW >= NR_MAX+1.
REQ-003 SHALL run on one clock with asynchronous, active-high reset: clk input 1 (all state on rising edge); rst input 1 (asynchronous, active-high).
REQ-004 SHALL have the following ports:
- nr_mode input 2: key length; 0=AES-128 (NR=10), 1=AES-192 (NR=12), 2=AES-256 (NR=14).
- rk_we input 1: round-key write strobe.
- rk_addr input RK_AW: round-key index, 0..NR_MAX.
- rk_wdata input 128: round-key word {w0,w1,w2,w3}, w0 in bits 127:96.
- rk_err output 1: one-cycle pulse when a round-key write is rejected.
- in_valid input 1: ciphertext valid.
- in_ready output 1: block can accept ciphertext.
- in_data input 128: ciphertext; byte 0 in bits 127:120, column-major.
- out_valid output 1: plaintext valid.
- out_ready input 1: sink accepts plaintext.
- out_data output 128: plaintext, same byte order as in_data.
- mode_err output 1: one-cycle pulse when a block is accepted with nr_mode=3.

Function
REQ-005 SHALL implement FIPS-197 InvCipher iteratively, one round per clock.
REQ-006 SHALL use states IDLE, ROUND, FINAL, DONE. Transitions:
- IDLE -> ROUND on accept.
- ROUND -> FINAL when rcnt==1.
- FINAL -> DONE.
- DONE -> IDLE on out_valid & out_ready.
REQ-007 SHALL drive in_ready high only in IDLE; accept = in_valid & in_ready.
REQ-008 SHALL do the following on the accept edge: latch NR from nr_mode; load state = in_data ^ rk[NR]; set rcnt = NR-1.
REQ-009 SHALL perform a full round on each ROUND edge: state = InvMixColumns(InvSubBytes(InvShiftRows(state)) ^ rk[rcnt]); rcnt decrements.
REQ-010 SHALL perform the final round on the FINAL edge: out_data = InvSubBytes(InvShiftRows(state)) ^ rk[0], with no InvMixColumns.
REQ-011 SHALL raise out_valid exactly NR+1 cycles after the accept edge: 11, 13 or 15 cycles.
REQ-012 SHALL hold out_valid and out_data stable in DONE until out_ready; with out_ready held high, IDLE is re-entered one cycle after the output handshake.
REQ-013 SHALL treat nr_mode=3 as NR=10 and pulse mode_err for one cycle on the accept edge.
REQ-014 SHALL write rk[rk_addr] = rk_wdata when rk_we is high in IDLE.
REQ-015 SHALL ignore rk_we in ROUND/FINAL/DONE, or with rk_addr > NR_MAX, and pulse rk_err the next cycle.
REQ-016 SHALL use pre-write round-key contents for a block accepted in the same cycle as a round-key write.
REQ-017 SHALL not sample in_data, in_valid or nr_mode outside IDLE; changes while busy have no effect.
REQ-018 SHALL use GF(2^8) modulus 0x11B; InvMixColumns coefficients are {0e,0b,0d,09}.

Reset
REQ-019 SHALL, on asynchronous rst assertion, set state to IDLE and clear rcnt, out_valid, out_data, rk_err and mode_err immediately.
REQ-020 SHALL set in_ready=1 the first edge after rst deasserts.
REQ-021 SHALL not clear round-key storage on rst; contents are undefined until written.
REQ-022 SHALL, on rst mid-operation, abort the block with no output produced.

Structure
REQ-023 SHALL place NR constants (10/12/14), nr_mode encodings and GF xtime/pmul functions in the shared package aes_pkg.
REQ-024 SHALL place one combinational round in sub-module aes_inv_round, with inputs state, rk, last flag and output next-state.
REQ-025 aes_inv_round SHALL reuse aes_inv_sbox for its 16 byte substitutions.

Verification
REQ-026 AES-128: preload rk[0..10] from key 000102030405060708090a0b0c0d0e0f, nr_mode=0, in_data 69c4e0d86a7b0430d8cdb78070b4c55a -> out_data 00112233445566778899aabbccddeeff, out_valid exactly 11 cycles after accept.
REQ-027 AES-192: key 000102...1617, nr_mode=1, ct dda97ca4864cdfe06eaf70a0ec0d7191 -> pt 00112233445566778899aabbccddeeff at 13 cycles.
REQ-028 AES-256: key 000102...1e1f, nr_mode=2, ct 8ea2b7ca516745bfeafc49904b496089 -> same pt at 15 cycles.
REQ-029 Backpressure: hold out_ready=0 for 20 cycles after out_valid -> out_data stable, in_ready=0 throughout; raise out_ready -> in_ready=1 the next cycle.
REQ-030 Busy key write: rk_we during ROUND -> rk_err pulses once, rk unchanged, result still correct; rk_addr=15 in IDLE -> rk_err pulses.
REQ-031 Reset mid-operation: rst at round 5 -> out_valid=0 immediately, in_ready=1 after release; the next vector decrypts correctly without reloading keys.
